// File: rtl/umq_pkg.sv
// Shared types for the unexpected-message queue: default field widths,
// header key / entry layouts and the one-hot scan FSM encoding.
package umq_pkg;

  localparam int UMQ_DEPTH         = 16;
  localparam int UMQ_RANK_BIT      = 8;
  localparam int UMQ_TAG_BIT       = 8;
  localparam int UMQ_COMM_BIT      = 2;
  localparam int UMQ_PAYLOAD_WIDTH = 32;

  // Matching key carried by every network header and every receive request.
  typedef struct packed {
    logic [UMQ_COMM_BIT-1:0] comm;
    logic [UMQ_RANK_BIT-1:0] src;
    logic [UMQ_TAG_BIT-1:0]  tag;
  } umq_key_t;

  // One queue slot at the default widths.
  typedef struct packed {
    logic                         valid;
    umq_key_t                     key;
    logic [UMQ_PAYLOAD_WIDTH-1:0] payload;
  } umq_entry_t;

  // One-hot scan controller states.
  typedef enum logic [1:0] {
    IDLE = 2'b01,
    SCAN = 2'b10
  } umq_state_t;

endpackage

// File: rtl/umq_key_match.sv
// Combinational compare of one queue entry against the latched receive key.
// The communicator is always compared; src/tag can be wildcarded.
module umq_key_match
  import umq_pkg::*;
#(
  parameter int RANK_BIT = UMQ_RANK_BIT,
  parameter int TAG_BIT  = UMQ_TAG_BIT,
  parameter int COMM_BIT = UMQ_COMM_BIT
) (
  input  logic                i_vld,
  input  logic [COMM_BIT-1:0] i_e_comm,
  input  logic [RANK_BIT-1:0] i_e_src,
  input  logic [TAG_BIT-1:0]  i_e_tag,
  input  logic [COMM_BIT-1:0] i_k_comm,
  input  logic [RANK_BIT-1:0] i_k_src,
  input  logic [TAG_BIT-1:0]  i_k_tag,
  input  logic                i_any_src,
  input  logic                i_any_tag,
  output logic                o_hit
);

  logic w_comm_eq;
  logic w_src_ok;
  logic w_tag_ok;

  assign w_comm_eq = (i_e_comm == i_k_comm);
  assign w_src_ok  = i_any_src || (i_e_src == i_k_src);
  assign w_tag_ok  = i_any_tag || (i_e_tag == i_k_tag);
  assign o_hit     = i_vld && w_comm_eq && w_src_ok && w_tag_ok;

endmodule

// File: rtl/umq_wildcard_cam.sv
// Unexpected-message queue: headers are appended in arrival order to a
// circular register file; a receive request walks it oldest-first, returns
// the first match and invalidates it. Holes left by removed entries are
// reclaimed at the head one slot per cycle.
// Storage is kept as per-field arrays so every width follows the module
// parameters rather than the package defaults.
module umq_wildcard_cam
  import umq_pkg::*;
#(
  parameter int DEPTH         = UMQ_DEPTH,
  parameter int RANK_BIT      = UMQ_RANK_BIT,
  parameter int TAG_BIT       = UMQ_TAG_BIT,
  parameter int COMM_BIT      = UMQ_COMM_BIT,
  parameter int PAYLOAD_WIDTH = UMQ_PAYLOAD_WIDTH,
  localparam int ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ins_valid,
  output logic                     ins_ready,
  input  logic [COMM_BIT-1:0]      ins_comm,
  input  logic [RANK_BIT-1:0]      ins_src,
  input  logic [TAG_BIT-1:0]       ins_tag,
  input  logic [PAYLOAD_WIDTH-1:0] ins_payload,
  input  logic                     find_valid,
  output logic                     find_ready,
  input  logic [COMM_BIT-1:0]      find_comm,
  input  logic [RANK_BIT-1:0]      find_src,
  input  logic [TAG_BIT-1:0]       find_tag,
  input  logic                     find_any_src,
  input  logic                     find_any_tag,
  output logic                     found,
  output logic                     not_found,
  output logic [RANK_BIT-1:0]      match_src,
  output logic [TAG_BIT-1:0]       match_tag,
  output logic [PAYLOAD_WIDTH-1:0] match_payload,
  output logic [ADDR_WIDTH:0]      count,
  output logic                     q_empty,
  output logic                     q_full
);

  // Pointers carry one extra bit so full (span==DEPTH) and empty differ.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  logic [DEPTH-1:0]         r_vld;
  logic [COMM_BIT-1:0]      r_comm [DEPTH];
  logic [RANK_BIT-1:0]      r_src  [DEPTH];
  logic [TAG_BIT-1:0]       r_tag  [DEPTH];
  logic [PAYLOAD_WIDTH-1:0] r_pay  [DEPTH];

  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [PW-1:0]            r_ptr;
  logic [PW-1:0]            r_stop;
  logic [PW-1:0]            r_count;
  umq_state_t               r_state;

  logic [COMM_BIT-1:0]      r_k_comm;
  logic [RANK_BIT-1:0]      r_k_src;
  logic [TAG_BIT-1:0]       r_k_tag;
  logic                     r_k_any_src;
  logic                     r_k_any_tag;

  logic [PW-1:0]            w_span;
  logic [PW-1:0]            w_ptr_nxt;
  logic [ADDR_WIDTH-1:0]    w_head_idx;
  logic [ADDR_WIDTH-1:0]    w_tail_idx;
  logic [ADDR_WIDTH-1:0]    w_ptr_idx;
  logic                     w_ins_acc;
  logic                     w_find_acc;
  logic                     w_reclaim;
  logic                     w_hit_raw;
  logic                     w_hit;

  assign w_span     = r_tail - r_head;
  assign w_ptr_nxt  = r_ptr + 1'b1;
  assign w_head_idx = r_head[ADDR_WIDTH-1:0];
  assign w_tail_idx = r_tail[ADDR_WIDTH-1:0];
  assign w_ptr_idx  = r_ptr[ADDR_WIDTH-1:0];

  assign ins_ready  = (w_span != DEPTH_P);
  assign q_full     = !ins_ready;
  assign find_ready = (r_state == IDLE);
  assign count      = r_count;
  assign q_empty    = (r_count == '0);

  assign w_ins_acc  = ins_valid && ins_ready;
  assign w_find_acc = find_valid && (r_state == IDLE);
  // A hole at the head is skipped so later inserts can reuse the slot.
  assign w_reclaim  = (w_span != '0) && !r_vld[w_head_idx];
  assign w_hit      = (r_state == SCAN) && w_hit_raw;

  umq_key_match #(
    .RANK_BIT (RANK_BIT),
    .TAG_BIT  (TAG_BIT),
    .COMM_BIT (COMM_BIT)
  ) u_match (
    .i_vld     (r_vld[w_ptr_idx]),
    .i_e_comm  (r_comm[w_ptr_idx]),
    .i_e_src   (r_src[w_ptr_idx]),
    .i_e_tag   (r_tag[w_ptr_idx]),
    .i_k_comm  (r_k_comm),
    .i_k_src   (r_k_src),
    .i_k_tag   (r_k_tag),
    .i_any_src (r_k_any_src),
    .i_any_tag (r_k_any_tag),
    .o_hit     (w_hit_raw)
  );

  // Header fields are written at the tail; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_ins_acc) begin
      r_comm[w_tail_idx] <= ins_comm;
      r_src[w_tail_idx]  <= ins_src;
      r_tag[w_tail_idx]  <= ins_tag;
      r_pay[w_tail_idx]  <= ins_payload;
    end
  end

  // Request key is captured when a request is accepted.
  always_ff @(posedge clk) begin
    if (w_find_acc) begin
      r_k_comm    <= find_comm;
      r_k_src     <= find_src;
      r_k_tag     <= find_tag;
      r_k_any_src <= find_any_src;
      r_k_any_tag <= find_any_tag;
    end
  end

  // Valid bits, head/tail pointers and the occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_ins_acc) begin
        r_vld[w_tail_idx] <= 1'b1;
        r_tail            <= r_tail + 1'b1;
      end
      // The scan slot always lies in [head, stop) so it never aliases the tail.
      if (w_hit) begin
        r_vld[w_ptr_idx] <= 1'b0;
      end
      if (w_reclaim) begin
        r_head <= r_head + 1'b1;
      end
      if (w_ins_acc && !w_hit) begin
        r_count <= r_count + 1'b1;
      end else if (!w_ins_acc && w_hit) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Scan controller; stop is a snapshot of tail so later inserts stay unseen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_stop        <= '0;
      found         <= 1'b0;
      not_found     <= 1'b0;
      match_src     <= '0;
      match_tag     <= '0;
      match_payload <= '0;
    end else begin
      found         <= 1'b0;
      not_found     <= 1'b0;
      match_src     <= '0;
      match_tag     <= '0;
      match_payload <= '0;
      case (r_state)
        IDLE: begin
          if (find_valid) begin
            r_ptr  <= r_head;
            r_stop <= r_tail;
            if (w_span == '0) begin
              not_found <= 1'b1;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (w_hit_raw) begin
            found         <= 1'b1;
            match_src     <= r_src[w_ptr_idx];
            match_tag     <= r_tag[w_ptr_idx];
            match_payload <= r_pay[w_ptr_idx];
            r_state       <= IDLE;
          end else if (w_ptr_nxt == r_stop) begin
            not_found <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_ptr <= w_ptr_nxt;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umq_wildcard_cam.sv
// Directed bench for the unexpected-message queue: exact and wildcard
// matching, ordering, full/drop behaviour, pointer wrap, snapshot
// semantics during a scan and reset in the middle of a scan.
module tb_umq_wildcard_cam;

  logic        clk = 1'b0;
  logic        rst;
  logic        ins_valid;
  logic        ins_ready;
  logic [1:0]  ins_comm;
  logic [7:0]  ins_src;
  logic [7:0]  ins_tag;
  logic [31:0] ins_payload;
  logic        find_valid;
  logic        find_ready;
  logic [1:0]  find_comm;
  logic [7:0]  find_src;
  logic [7:0]  find_tag;
  logic        find_any_src;
  logic        find_any_tag;
  logic        found;
  logic        not_found;
  logic [7:0]  match_src;
  logic [7:0]  match_tag;
  logic [31:0] match_payload;
  logic [4:0]  count;
  logic        q_empty;
  logic        q_full;

  int errors = 0;
  int checks = 0;

  // Result of the most recent request.
  logic        t_fnd;
  logic        t_nf;
  logic [31:0] t_pay;
  logic [7:0]  t_src;
  logic [7:0]  t_tag;
  int          t_lat;

  always #5 clk = ~clk;

  umq_wildcard_cam dut (
    .clk           (clk),
    .rst           (rst),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins_comm      (ins_comm),
    .ins_src       (ins_src),
    .ins_tag       (ins_tag),
    .ins_payload   (ins_payload),
    .find_valid    (find_valid),
    .find_ready    (find_ready),
    .find_comm     (find_comm),
    .find_src      (find_src),
    .find_tag      (find_tag),
    .find_any_src  (find_any_src),
    .find_any_tag  (find_any_tag),
    .found         (found),
    .not_found     (not_found),
    .match_src     (match_src),
    .match_tag     (match_tag),
    .match_payload (match_payload),
    .count         (count),
    .q_empty       (q_empty),
    .q_full        (q_full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [1:0] c, input logic [7:0] s, input logic [7:0] t,
                     input logic [31:0] p);
    ins_valid   = 1'b1;
    ins_comm    = c;
    ins_src     = s;
    ins_tag     = t;
    ins_payload = p;
    tick();
    ins_valid   = 1'b0;
  endtask

  // Waits (bounded) for a result pulse; t_lat counts cycles since accept.
  task automatic wait_result(input int start_lat);
    t_fnd = 1'b0;
    t_nf  = 1'b0;
    t_pay = '0;
    t_src = '0;
    t_tag = '0;
    t_lat = 0;
    for (int k = start_lat; k < start_lat + 40; k++) begin
      if (found || not_found) begin
        t_fnd = found;
        t_nf  = not_found;
        t_pay = match_payload;
        t_src = match_src;
        t_tag = match_tag;
        t_lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic find_req(input logic [1:0] c, input logic [7:0] s, input logic [7:0] t,
                          input logic as, input logic at);
    find_valid   = 1'b1;
    find_comm    = c;
    find_src     = s;
    find_tag     = t;
    find_any_src = as;
    find_any_tag = at;
    tick();
    find_valid   = 1'b0;
    wait_result(1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (count !== 5'd0 || q_empty !== 1'b1 || q_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_occupancy: count=%0d empty=%b full=%b, want 0/1/0", count, q_empty, q_full);
    end
    checks++;
    if (ins_ready !== 1'b1 || find_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: ins_ready=%b find_ready=%b, want 1/1", ins_ready, find_ready);
    end
    checks++;
    if (found !== 1'b0 || not_found !== 1'b0 || match_payload !== 32'd0) begin
      errors++;
      $display("FAIL reset_result: found=%b nf=%b pay=%h, want 0/0/0", found, not_found, match_payload);
    end
    find_req(2'd0, 8'd3, 8'd5, 1'b0, 1'b0);
    checks++;
    if (t_nf !== 1'b1 || t_fnd !== 1'b0 || t_lat !== 1) begin
      errors++;
      $display("FAIL empty_find: nf=%b found=%b lat=%0d, want 1/0/1", t_nf, t_fnd, t_lat);
    end
    checks++;
    if (count !== 5'd0 || q_empty !== 1'b1) begin
      errors++;
      $display("FAIL empty_find_count: count=%0d empty=%b, want 0/1", count, q_empty);
    end
  endtask

  task automatic test_exact_order();
    ins(2'd0, 8'd3, 8'd5, 32'hA);
    ins(2'd0, 8'd3, 8'd5, 32'hB);
    checks++;
    if (count !== 5'd2) begin
      errors++;
      $display("FAIL insert_count: got %0d want 2", count);
    end
    find_req(2'd0, 8'd3, 8'd5, 1'b0, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'hA || t_lat !== 2 || t_src !== 8'd3 || t_tag !== 8'd5) begin
      errors++;
      $display("FAIL exact_first: found=%b pay=%h lat=%0d src=%0d tag=%0d, want 1/a/2/3/5",
               t_fnd, t_pay, t_lat, t_src, t_tag);
    end
    checks++;
    if (count !== 5'd1) begin
      errors++;
      $display("FAIL exact_first_count: got %0d want 1", count);
    end
    // Head still points at the removed slot when this request is accepted.
    find_req(2'd0, 8'd3, 8'd5, 1'b0, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'hB || t_lat !== 3) begin
      errors++;
      $display("FAIL exact_second: found=%b pay=%h lat=%0d, want 1/b/3", t_fnd, t_pay, t_lat);
    end
    checks++;
    if (count !== 5'd0 || q_empty !== 1'b1) begin
      errors++;
      $display("FAIL exact_second_count: count=%0d empty=%b, want 0/1", count, q_empty);
    end
  endtask

  task automatic test_wildcard();
    ins(2'd0, 8'd1, 8'd7, 32'h11);
    ins(2'd0, 8'd2, 8'd7, 32'h22);
    find_req(2'd0, 8'd9, 8'd7, 1'b1, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'h11 || t_src !== 8'd1 || t_lat !== 2) begin
      errors++;
      $display("FAIL any_src: found=%b pay=%h src=%0d lat=%0d, want 1/11/1/2", t_fnd, t_pay, t_src, t_lat);
    end
    find_req(2'd0, 8'd2, 8'd0, 1'b0, 1'b1);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'h22 || t_tag !== 8'd7 || t_lat !== 3) begin
      errors++;
      $display("FAIL any_tag: found=%b pay=%h tag=%0d lat=%0d, want 1/22/7/3", t_fnd, t_pay, t_tag, t_lat);
    end
    ins(2'd0, 8'd4, 8'd4, 32'h44);
    find_req(2'd1, 8'd4, 8'd4, 1'b1, 1'b1);
    checks++;
    if (t_nf !== 1'b1 || t_fnd !== 1'b0 || match_payload !== 32'd0) begin
      errors++;
      $display("FAIL comm_mismatch: nf=%b found=%b pay=%h, want 1/0/0", t_nf, t_fnd, match_payload);
    end
    find_req(2'd0, 8'd4, 8'd4, 1'b0, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'h44 || count !== 5'd0) begin
      errors++;
      $display("FAIL comm_keep: found=%b pay=%h count=%0d, want 1/44/0", t_fnd, t_pay, count);
    end
  endtask

  task automatic test_full_wrap();
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      ins(2'd0, 8'(i), 8'(i), 32'h100 + 32'(i));
    end
    checks++;
    if (count !== 5'd16 || q_full !== 1'b1 || ins_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill: count=%0d full=%b ins_ready=%b, want 16/1/0", count, q_full, ins_ready);
    end
    ins(2'd0, 8'h77, 8'h77, 32'h999);
    checks++;
    if (count !== 5'd16) begin
      errors++;
      $display("FAIL drop_count: got %0d want 16", count);
    end
    find_req(2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'h100 || t_lat !== 2 || count !== 5'd15) begin
      errors++;
      $display("FAIL full_hit: found=%b pay=%h lat=%0d count=%0d, want 1/100/2/15", t_fnd, t_pay, t_lat, count);
    end
    checks++;
    if (ins_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_reclaim: got %b want 0", ins_ready);
    end
    tick();
    checks++;
    if (ins_ready !== 1'b1 || q_full !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reclaim: ins_ready=%b full=%b, want 1/0", ins_ready, q_full);
    end
    ins(2'd0, 8'h55, 8'h66, 32'h200);
    checks++;
    if (count !== 5'd16 || q_full !== 1'b1) begin
      errors++;
      $display("FAIL refill: count=%0d full=%b, want 16/1", count, q_full);
    end
    // Newest entry sits at offset 15, physically past the index wrap.
    find_req(2'd0, 8'h55, 8'h66, 1'b0, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'h200 || t_lat !== 17) begin
      errors++;
      $display("FAIL wrap_hit: found=%b pay=%h lat=%0d, want 1/200/17", t_fnd, t_pay, t_lat);
    end
    find_req(2'd0, 8'd0, 8'd3, 1'b1, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'h103) begin
      errors++;
      $display("FAIL wrap_oldest: found=%b pay=%h, want 1/103", t_fnd, t_pay);
    end
    find_req(2'd0, 8'h77, 8'h77, 1'b0, 1'b0);
    checks++;
    if (t_nf !== 1'b1 || t_fnd !== 1'b0) begin
      errors++;
      $display("FAIL dropped_absent: nf=%b found=%b, want 1/0", t_nf, t_fnd);
    end
  endtask

  task automatic test_snapshot();
    logic early;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      ins(2'd1, 8'(i), 8'(i), 32'(i));
    end
    find_valid   = 1'b1;
    find_comm    = 2'd0;
    find_src     = 8'd9;
    find_tag     = 8'd9;
    find_any_src = 1'b0;
    find_any_tag = 1'b0;
    tick();
    find_valid   = 1'b0;
    early        = found | not_found;
    ins_valid    = 1'b1;
    ins_comm     = 2'd0;
    ins_src      = 8'd9;
    ins_tag      = 8'd9;
    ins_payload  = 32'hCAFE;
    tick();
    ins_valid    = 1'b0;
    wait_result(2);
    checks++;
    if (early !== 1'b0 || t_nf !== 1'b1 || t_fnd !== 1'b0 || t_lat !== 5) begin
      errors++;
      $display("FAIL snapshot_scan: early=%b nf=%b found=%b lat=%0d, want 0/1/0/5", early, t_nf, t_fnd, t_lat);
    end
    checks++;
    if (count !== 5'd5) begin
      errors++;
      $display("FAIL snapshot_count: got %0d want 5", count);
    end
    find_req(2'd0, 8'd9, 8'd9, 1'b0, 1'b0);
    checks++;
    if (t_fnd !== 1'b1 || t_pay !== 32'hCAFE || t_lat !== 6) begin
      errors++;
      $display("FAIL snapshot_new: found=%b pay=%h lat=%0d, want 1/cafe/6", t_fnd, t_pay, t_lat);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic pulse;
    find_valid   = 1'b1;
    find_comm    = 2'd0;
    find_src     = 8'd9;
    find_tag     = 8'd9;
    find_any_src = 1'b0;
    find_any_tag = 1'b0;
    tick();
    find_valid   = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (found !== 1'b0 || not_found !== 1'b0 || count !== 5'd0 || find_ready !== 1'b1 || q_empty !== 1'b1) begin
      errors++;
      $display("FAIL rst_scan: found=%b nf=%b count=%0d find_ready=%b empty=%b, want 0/0/0/1/1",
               found, not_found, count, find_ready, q_empty);
    end
    pulse = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pulse = pulse | found | not_found;
    end
    checks++;
    if (pulse !== 1'b0) begin
      errors++;
      $display("FAIL rst_scan_quiet: pulse=%b want 0", pulse);
    end
  endtask

  initial begin
    rst          = 1'b1;
    ins_valid    = 1'b0;
    ins_comm     = '0;
    ins_src      = '0;
    ins_tag      = '0;
    ins_payload  = '0;
    find_valid   = 1'b0;
    find_comm    = '0;
    find_src     = '0;
    find_tag     = '0;
    find_any_src = 1'b0;
    find_any_tag = 1'b0;
    test_reset();
    test_exact_order();
    test_wildcard();
    test_full_wrap();
    test_snapshot();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
